clock_monitor: RTL and testbench

Measures a slow clock such as the output of `clock_divider` against the fast system clock, and reports its period, high time and lock status. It checks the measured period against an expected divisor and tolerance. It flags periods that are too fast, too slow, or missing entirely. It sits beside the divided-clock consumers and runs as a self-check of the clock tree on the FPGA.

---
 rtl/clock_monitor_pkg.sv | 23 ++
 rtl/edge_sync.sv | 50 +++++
 rtl/clock_monitor.sv | 186 ++++++++++++++++++
 tb/tb_clock_monitor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clock_monitor_pkg
//   Shared definitions for the clock monitor:
//     - mon_state_e : monitor state encoding (IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3)
//     - cnt_width() : minimum counter width that can hold 2*expected_div plus
//                     one more count, so that a saturated cnt+1 still fits.
// -----------------------------------------------------------------------------
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_LOST    = 2'd3
  } mon_state_e;

  // Width needed for a counter that saturates at 2*expected_div and is
  // reported as cnt+1.
  function automatic int cnt_width(input int expected_div);
    return $clog2(2 * expected_div + 2);
  endfunction

endpackage : clock_monitor_pkg

// File: rtl/edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
//   Brings the monitored clock into the clk_in domain and detects its rising
//   edges.
//
//   Build option: CLOCK_MONITOR_SYNC_EN
//     defined   : mon_in passes through a 2-flop synchronizer (mon_in may be
//                 asynchronous to clk_in; adds 2 cycles of latency).
//     undefined : mon_s = mon_in directly (mon_in must be derived from clk_in).
//
//   Ports
//     clk_in  in  system clock
//     reset   in  synchronous, active-high reset
//     mon_in  in  monitored slow clock
//     mon_s   out sampled monitored clock
//     rise    out one-cycle pulse on a 0->1 transition of mon_s
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic mon_in,
  output logic mon_s,
  output logic rise
);

`ifdef CLOCK_MONITOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_in) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], mon_in};
  end

  assign mon_s = sync_q[1];
`else
  assign mon_s = mon_in;
`endif

  logic prev;

  // prev is cleared on reset so a level already high when reset releases is
  // seen as a rise and treated as the first (partial) edge.
  always_ff @(posedge clk_in) begin
    if (reset) prev <= 1'b0;
    else       prev <= mon_s;
  end

  assign rise = mon_s & ~prev;

endmodule : edge_sync

// File: rtl/clock_monitor.sv
// -----------------------------------------------------------------------------
// clock_monitor
//   Measures a slow clock (mon_in) against clk_in: rise-to-rise period, high
//   time within that period, and lock status against an expected divisor with
//   an absolute tolerance. Flags periods that are too fast, too slow, or
//   missing (timeout after 2*EXPECTED_DIV cycles with no rise).
//
//   Build option: CLOCK_MONITOR_SYNC_EN (see edge_sync) selects a 2-flop
//   synchronizer on mon_in; latency mon_in rise -> meas_valid is 3 cycles
//   with it, 1 cycle without. Measured values are identical either way.
//
//   Parameters
//     EXPECTED_DIV  expected period of mon_in in clk_in cycles
//     TOLERANCE     allowed absolute deviation from EXPECTED_DIV
//     LOCK_CNT      consecutive in-tolerance periods needed to lock
//     CNT_W         counter width; must hold 2*EXPECTED_DIV (see cnt_width())
//
//   Ports
//     clk_in      in  system clock
//     reset       in  synchronous, active-high reset
//     mon_in      in  monitored slow clock
//     err_clr     in  single-cycle clear of the sticky error flags
//     period      out last measured rise-to-rise period
//     high_time   out high cycles within that period
//     meas_valid  out one-cycle pulse: period/high_time updated this cycle
//     locked      out state is LOCKED
//     lost        out state is LOST
//     err_fast    out sticky: a period below EXPECTED_DIV-TOLERANCE
//     err_slow    out sticky: a period above EXPECTED_DIV+TOLERANCE, or timeout
// -----------------------------------------------------------------------------
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int EXPECTED_DIV = 100_000,
  parameter int TOLERANCE    = 16,
  parameter int LOCK_CNT     = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             mon_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             lost,
  output logic             err_fast,
  output logic             err_slow
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int GOOD_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  // Bounds are kept at CNT_W+1 bits so cnt+1 never wraps and a tolerance
  // larger than the divisor clamps the lower bound to 0 instead of underflowing.
  localparam logic [CNT_W:0] LO_BOUND =
    (TOLERANCE >= EXPECTED_DIV) ? '0 : (CNT_W+1)'(EXPECTED_DIV - TOLERANCE);
  localparam logic [CNT_W:0] HI_BOUND = (CNT_W+1)'(EXPECTED_DIV + TOLERANCE);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(2 * EXPECTED_DIV);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(2 * EXPECTED_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   EXT_ONE = (CNT_W+1)'(1);

  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic mon_s;
  logic rise;

  edge_sync u_edge_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .mon_in (mon_in),
    .mon_s  (mon_s),
    .rise   (rise)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mon_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  hcnt;
  logic [GOOD_W-1:0] good;

  // ---------------------------------------------------------------------------
  // Measurement decode (valid in the rise cycle)
  // ---------------------------------------------------------------------------
  logic [CNT_W:0]    meas_len;
  logic              too_fast;
  logic              too_slow;
  logic              in_tol;
  logic              timeout;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  hcnt_nxt;
  logic [GOOD_W-1:0] good_inc;

  assign meas_len = {1'b0, cnt} + EXT_ONE;
  assign too_fast = (meas_len < LO_BOUND);
  assign too_slow = (meas_len > HI_BOUND);
  assign in_tol   = ~too_fast & ~too_slow;
  assign timeout  = (cnt == CNT_TMO);
  assign good_inc = good + GOOD_ONE;

  // Both counters saturate so a stuck mon_in cannot wrap them back into range.
  assign cnt_nxt  = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
  assign hcnt_nxt = (hcnt == CNT_SAT) ? hcnt
                                      : hcnt + {{(CNT_W-1){1'b0}}, mon_s};

  // ---------------------------------------------------------------------------
  // Counters, FSM, measurement registers and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      good       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      err_fast   <= 1'b0;
      err_slow   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      // Clear first; any error raised later in this block overrides it.
      if (err_clr) begin
        err_fast <= 1'b0;
        err_slow <= 1'b0;
      end

      if (rise) begin
        cnt  <= '0;
        hcnt <= CNT_ONE;
      end else begin
        cnt  <= cnt_nxt;
        hcnt <= hcnt_nxt;
      end

      if (rise) begin
        // A rise always wins over a coincident timeout.
        unique case (state)
          S_IDLE, S_LOST: begin
            // First period after IDLE/LOST is partial: no measurement.
            state <= S_ACQUIRE;
            good  <= '0;
          end
          S_ACQUIRE, S_LOCKED: begin
            period     <= meas_len[CNT_W-1:0];
            high_time  <= hcnt;
            meas_valid <= 1'b1;
            if (in_tol) begin
              if (state == S_ACQUIRE) begin
                good <= good_inc;
                if (good_inc == GOOD_LOCK) state <= S_LOCKED;
              end
            end else begin
              state <= S_ACQUIRE;
              good  <= '0;
              if (too_fast) err_fast <= 1'b1;
              if (too_slow) err_slow <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (timeout && (state != S_LOST)) begin
        state    <= S_LOST;
        good     <= '0;
        err_slow <= 1'b1;
      end
    end
  end

  // Decoded from the state register only: no path from mon_in.
  assign locked = (state == S_LOCKED);
  assign lost   = (state == S_LOST);

endmodule : clock_monitor

// File: tb/tb_clock_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_monitor
//   Directed stimulus for clock_monitor with EXPECTED_DIV=10, TOLERANCE=1,
//   LOCK_CNT=4. Each measurement expected from a rise is queued when that rise
//   is driven; a separate monitor pops and compares on every meas_valid.
// -----------------------------------------------------------------------------
module tb_clock_monitor;
  import clock_monitor_pkg::*;

  localparam int DIV = 10;
  localparam int TOL = 1;
  localparam int LCK = 4;
  localparam int CW  = cnt_width(DIV);
`ifdef CLOCK_MONITOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic          mon_in = 1'b0;
  logic          err_clr = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          locked;
  logic          lost;
  logic          err_fast;
  logic          err_slow;

  clock_monitor #(
    .EXPECTED_DIV (DIV),
    .TOLERANCE    (TOL),
    .LOCK_CNT     (LCK),
    .CNT_W        (CW)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .mon_in     (mon_in),
    .err_clr    (err_clr),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .lost       (lost),
    .err_fast   (err_fast),
    .err_slow   (err_slow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int p;
    int h;
    bit lk;
    bit ef;
    bit es;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   prv_p  = 0;
  int   prv_h  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented measurement against the queue head.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (!reset && meas_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas got period %0d high %0d expected none",
                 period, high_time);
      end else begin
        e = sb.pop_front();
        chk("meas_period",    int'(period),    e.p);
        chk("meas_high_time", int'(high_time), e.h);
        chk("meas_locked",    int'(locked),    int'(e.lk));
        chk("meas_err_fast",  int'(err_fast),  int'(e.ef));
        chk("meas_err_slow",  int'(err_slow),  int'(e.es));
      end
    end
  end

  task automatic cyc(input bit v);
    mon_in = v;
    @(posedge clk_in);
    #1;
  endtask

  // One period of p cycles, h high. If meas, the rise starting it is expected
  // to report the previous period with the given post-edge flags.
  // clr_rise pulses err_clr in the cycle the DUT sees the rise; clr_mid pulses
  // it later inside the period.
  task automatic per(input int p, input int h, input bit meas,
                     input bit lk, input bit ef, input bit es,
                     input bit clr_mid, input bit clr_rise);
    if (meas) sb.push_back('{prv_p, prv_h, lk, ef, es});
    for (int i = 0; i < p; i++) begin
      err_clr = (clr_rise && i == LAT) || (clr_mid && i == LAT + 3);
      cyc(i < h);
    end
    err_clr = 1'b0;
    prv_p = p;
    prv_h = h;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"},     int'(period),     0);
    chk({tag, "_high_time"},  int'(high_time),  0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_locked"},     int'(locked),     0);
    chk({tag, "_lost"},       int'(lost),       0);
    chk({tag, "_err_fast"},   int'(err_fast),   0);
    chk({tag, "_err_slow"},   int'(err_slow),   0);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // Nominal: first rise silent, lock on 4th measurement; next period slow
    per(10, 5, 0, 0, 0, 0, 0, 0);
    per(10, 5, 1, 0, 0, 0, 0, 0);
    per(10, 5, 1, 0, 0, 0, 0, 0);
    per(10, 5, 1, 0, 0, 0, 0, 0);
    per(12, 5, 1, 1, 0, 0, 0, 0);
    // Slow 12 drops lock, then relock over 4 nominal periods; next period fast
    per(10, 5, 1, 0, 0, 1, 0, 0);
    per(10, 5, 1, 0, 0, 1, 0, 0);
    per(10, 5, 1, 0, 0, 1, 0, 0);
    per(10, 5, 1, 0, 0, 1, 0, 0);
    per( 8, 4, 1, 1, 0, 1, 0, 0);
    // Fast 8 drops lock; err_clr alone then clears both flags
    per( 8, 4, 1, 0, 1, 1, 1, 0);
    chk("clr_err_fast", int'(err_fast), 0);
    chk("clr_err_slow", int'(err_slow), 0);
    // err_clr coincident with another fast period: error wins
    per(10, 5, 1, 0, 1, 0, 0, 1);
    // Boundaries: 9 and 11 are in tolerance and count towards lock, 12 is not
    per( 9, 5, 1, 0, 1, 0, 0, 0);
    per(11, 5, 1, 0, 1, 0, 0, 0);
    per(10, 5, 1, 0, 1, 0, 0, 0);
    per(12, 6, 1, 1, 1, 0, 0, 0);
    per(10, 5, 1, 0, 1, 1, 0, 0);
    per(10, 5, 1, 0, 1, 1, 1, 0);

    // Timeout: LOST exactly 20 cycles after the last rise
    sb.push_back('{prv_p, prv_h, 1'b0, 1'b0, 1'b0});
    repeat (5) cyc(1'b1);
    repeat (15 + LAT) cyc(1'b0);
    chk("tmo_early_lost",     int'(lost),     0);
    chk("tmo_early_err_slow", int'(err_slow), 0);
    cyc(1'b0);
    chk("tmo_lost",     int'(lost),     1);
    chk("tmo_err_slow", int'(err_slow), 1);
    chk("tmo_locked",   int'(locked),   0);
    repeat (10) cyc(1'b0);
    chk("tmo_hold_lost", int'(lost), 1);

    // Recovery: first rise silent, second measures
    per(10, 5, 0, 0, 0, 0, 0, 0);
    chk("rec_lost", int'(lost), 0);
    per(10, 5, 1, 0, 0, 1, 0, 0);

    // Reset 5 cycles after a rise
    sb.push_back('{prv_p, prv_h, 1'b0, 1'b0, 1'b1});
    repeat (5) cyc(1'b1);
    reset = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    chk_zero("midrst");
    reset = 1'b0;
    per(10, 5, 0, 0, 0, 0, 0, 0);
    per(10, 5, 1, 0, 0, 0, 0, 0);
    per(10, 5, 1, 0, 0, 0, 0, 0);
    repeat (3 + LAT) cyc(1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_clock_monitor
